seg_scan_bcd_counter: RTL

- Multi-digit BCD up/down counter with a time-multiplexed display scanner.
- Directly upstream of the 7-segment decoder: it presents one 4-bit BCD digit per scan slot on `data` for the decoder.
- Drives the matching active-low digit-select lines so one decoder serves all digits.
- Used for stopwatch/counter demos on the board display.

---
 rtl/seg_pkg.sv | 15 +
 rtl/bcd_digit.sv | 30 +++
 rtl/seg_scan_bcd_counter.sv | 89 ++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types, BCD limits and width helper for the scanned BCD counter.
// Pure declarations; no latency or flow control.
package seg_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   // Width of a counter holding 0..n-1; never below one bit so n=1 still yields a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: value updates the cycle after step; carry_out is combinational.
// No backpressure; clr wins over step.
module bcd_digit
   import seg_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic step,
   input  logic up,
   output bcd_t value,
   output logic carry_out
);

   assign carry_out = step & (up ? (value == BCD_MAX) : (value == BCD_MIN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= BCD_MIN;
      end else if (clr) begin
         value <= BCD_MIN;
      end else if (step) begin
         if (up)
            value <= (value == BCD_MAX) ? BCD_MIN : value + 4'd1;
         else
            value <= (value == BCD_MIN) ? BCD_MAX : value - 4'd1;
      end
   end

endmodule

// File: rtl/seg_scan_bcd_counter.sv
// BCD up/down counter (bcd/wrap one cycle after tick) with a free-running digit scanner (data/dig_sel one cycle behind).
// No backpressure: en gates counting, clr clears synchronously, the scanner never stalls.
module seg_scan_bcd_counter
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  up,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  wrap,
   output bcd_t                  data,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int TW = cnt_width(TICK_DIV);
   localparam int SW = cnt_width(SCAN_DIV);
   localparam int IW = cnt_width(DIGITS);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [DIGITS:0] carry;
   bcd_t            digit_val [DIGITS];
   logic [SW-1:0]   scan_cnt;
   logic [IW-1:0]   scan_idx;

   assign tick = en & (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tick_cnt <= '0;
      else if (clr || tick)
         tick_cnt <= '0;
      else if (en)
         tick_cnt <= tick_cnt + TW'(1);
   end

   // Masking the chain input with clr keeps every carry, and hence wrap, low during a clear.
   assign carry[0] = tick & ~clr;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr       (clr),
         .step      (carry[i]),
         .up        (up),
         .value     (digit_val[i]),
         .carry_out (carry[i+1])
      );
      assign bcd[4*i +: 4] = digit_val[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wrap <= 1'b0;
      else
         wrap <= carry[DIGITS];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
         data     <= BCD_MIN;
         dig_sel  <= ~DIGITS'(1);
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         data    <= digit_val[scan_idx];
         dig_sel <= ~(DIGITS'(1) << scan_idx);
      end
   end

endmodule
